// File: rtl/ddr3_avalon_bridge.sv
// Turns one held pipeline request into a single 128-bit Avalon-MM transfer and pulses a completion.
// Optional watchdog: define DDR3_BRIDGE_TIMEOUT_EN to abort stalled transfers and flag bridge_error.
module ddr3_avalon_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  sdram_address,
  input  logic         rd_en,
  input  logic         wr_en,
  input  logic [127:0] write_data_input,
  output logic [127:0] read_data,
  output logic         read_complete,
  output logic         write_complete,
  output logic [31:0]  avm_address,
  output logic         avm_read,
  output logic         avm_write,
  output logic [127:0] avm_writedata,
  output logic [15:0]  avm_byteenable,
  input  logic         avm_waitrequest,
  input  logic [127:0] avm_readdata,
  input  logic         avm_readdatavalid,
  output logic         bridge_error
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWrReq   = 3'd1;
  localparam logic [2:0] StRdReq   = 3'd2;
  localparam logic [2:0] StRdWait  = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;

  logic [2:0]   state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [127:0] rdata_q, rdata_d;
  logic         rd_cpl_q, rd_cpl_d;
  logic         wr_cpl_q, wr_cpl_d;
  logic         err_q, err_d;
  logic         timeout;

  logic unused_addr;
  assign unused_addr = ^sdram_address[31:28];

`ifdef DDR3_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_q, tmo_d;
  logic        busy;

  assign busy    = (state_q == StWrReq) || (state_q == StRdReq) || (state_q == StRdWait);
  assign timeout = busy && (tmo_q >= TmoLast);

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (busy) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_cpl_d = 1'b0;
    wr_cpl_d = 1'b0;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        // Write has priority when both requests are raised together.
        if (wr_en) begin
          addr_d  = BASE_ADDR + {sdram_address[27:0], 4'b0000};
          wdata_d = write_data_input;
          state_d = StWrReq;
        end else if (rd_en) begin
          addr_d  = BASE_ADDR + {sdram_address[27:0], 4'b0000};
          state_d = StRdReq;
        end
      end
      StWrReq: begin
        if (!avm_waitrequest) begin
          wr_cpl_d = 1'b1;
          state_d  = StRelease;
        end else if (timeout) begin
          wr_cpl_d = 1'b1;
          err_d    = 1'b1;
          state_d  = StRelease;
        end
      end
      StRdReq: begin
        if (!avm_waitrequest) begin
          state_d = StRdWait;
        end else if (timeout) begin
          rd_cpl_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = StRelease;
        end
      end
      StRdWait: begin
        if (avm_readdatavalid) begin
          rdata_d  = avm_readdata;
          rd_cpl_d = 1'b1;
          state_d  = StRelease;
        end else if (timeout) begin
          rd_cpl_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = StRelease;
        end
      end
      StRelease: begin
        // Hold here until the requester drops, so a held request is never re-issued.
        if (!rd_en && !wr_en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_cpl_q <= 1'b0;
      wr_cpl_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_cpl_q <= rd_cpl_d;
      wr_cpl_q <= wr_cpl_d;
      err_q    <= err_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_read       = (state_q == StRdReq);
  assign avm_write      = (state_q == StWrReq);
  assign avm_byteenable = 16'hFFFF;
  assign read_data      = rdata_q;
  assign read_complete  = rd_cpl_q;
  assign write_complete = wr_cpl_q;
  assign bridge_error   = err_q;

endmodule

// File: tb/tb_ddr3_avalon_bridge.sv
// Directed and random bench for ddr3_avalon_bridge; a word-indexed memory model predicts read data.
// Covers the DDR3_BRIDGE_TIMEOUT_EN watchdog when that macro is defined.
module tb_ddr3_avalon_bridge;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  sdram_address = '0;
  logic         rd_en = 1'b0;
  logic         wr_en = 1'b0;
  logic [127:0] write_data_input = '0;
  logic [127:0] read_data;
  logic         read_complete;
  logic         write_complete;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic         avm_waitrequest = 1'b0;
  logic [127:0] avm_readdata = '0;
  logic         avm_readdatavalid = 1'b0;
  logic         bridge_error;

  int errors = 0;
  int checks = 0;

  // Reference model: word index -> last written data.  Slave model: byte address -> stored data.
  logic [127:0] ref_mem   [int unsigned];
  logic [127:0] slave_mem [int unsigned];

  ddr3_avalon_bridge #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .sdram_address     (sdram_address),
    .rd_en             (rd_en),
    .wr_en             (wr_en),
    .write_data_input  (write_data_input),
    .read_data         (read_data),
    .read_complete     (read_complete),
    .write_complete    (write_complete),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .bridge_error      (bridge_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_addr(input logic [31:0] addr);
    return 32'(BASE + 32'(addr[27:0]) * 32'd16);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [127:0] data, input int nwait,
                          input bit with_rd, input int hold);
    logic [31:0] ea;
    ea = byte_addr(addr);
    sdram_address    = addr;
    write_data_input = data;
    wr_en            = 1'b1;
    rd_en            = with_rd;
    @(negedge clock);
    write_data_input = rnd128();  // bridge must use its captured copy
    for (int i = 0; i <= nwait; i++) begin
      avm_waitrequest = (i < nwait);
      check("wr_avm_write", avm_write, 1'b1);
      check("wr_avm_read", avm_read, 1'b0);
      check("wr_address", avm_address, ea);
      check("wr_writedata", avm_writedata, data);
      check("wr_byteenable", avm_byteenable, 16'hFFFF);
      check("wr_complete_early", write_complete, 1'b0);
      if (!avm_waitrequest && avm_write) slave_mem[avm_address] = avm_writedata;
      @(negedge clock);
    end
    avm_waitrequest = 1'b0;
    ref_mem[32'(addr[27:0])] = data;
    check("wr_complete", write_complete, 1'b1);
    check("wr_write_dropped", avm_write, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("wr_hold_complete", write_complete, 1'b0);
      check("wr_hold_no_write", avm_write, 1'b0);
      check("wr_hold_no_read", avm_read, 1'b0);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(negedge clock);
    check("wr_complete_single", write_complete, 1'b0);
    check("wr_idle_no_write", avm_write, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int nwait, input int lat, input int hold);
    logic [31:0]  ea;
    logic [127:0] ed;
    int           nread;
    ea    = byte_addr(addr);
    ed    = ref_mem.exists(32'(addr[27:0])) ? ref_mem[32'(addr[27:0])] : {96'h0, ea};
    nread = 0;
    sdram_address = addr;
    rd_en         = 1'b1;
    wr_en         = 1'b0;
    @(negedge clock);
    for (int i = 0; i <= nwait; i++) begin
      avm_waitrequest = (i < nwait);
      if (avm_read) nread++;
      check("rd_address", avm_address, ea);
      check("rd_avm_write", avm_write, 1'b0);
      @(negedge clock);
    end
    avm_waitrequest = 1'b0;
    check("rd_read_cycles", 32'(nread), 32'(nwait + 1));
    for (int j = 1; j <= lat; j++) begin
      check("rd_wait_no_read", avm_read, 1'b0);
      check("rd_complete_early", read_complete, 1'b0);
      avm_readdatavalid = (j == lat);
      if (j == lat) begin
        avm_readdata = slave_mem.exists(avm_address) ? slave_mem[avm_address]
                                                     : {96'h0, avm_address};
      end else begin
        avm_readdata = rnd128();
      end
      @(negedge clock);
    end
    avm_readdatavalid = 1'b0;
    avm_readdata      = rnd128();
    check("rd_complete", read_complete, 1'b1);
    check("rd_data", read_data, ed);
    for (int i = 0; i < hold; i++) begin
      avm_readdatavalid = (i % 2 == 0);  // stray valids outside RD_WAIT are ignored
      @(negedge clock);
      check("rd_hold_complete", read_complete, 1'b0);
      check("rd_hold_no_read", avm_read, 1'b0);
      check("rd_hold_data", read_data, ed);
    end
    avm_readdatavalid = 1'b0;
    rd_en = 1'b0;
    @(negedge clock);
    check("rd_complete_single", read_complete, 1'b0);
    check("rd_data_held", read_data, ed);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_avm_read", avm_read, 1'b0);
    check("rst_avm_write", avm_write, 1'b0);
    check("rst_read_complete", read_complete, 1'b0);
    check("rst_write_complete", write_complete, 1'b0);
    check("rst_read_data", read_data, '0);
    check("rst_avm_address", avm_address, '0);
    check("rst_bridge_error", bridge_error, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    // Zero-wait write to word 5
    do_write(32'd5, {16{8'hA5}}, 0, 1'b0, 0);
    check("wr5_byte_address", slave_mem.exists(32'h2000_0050), 1'b1);

    // Read with 3 stall cycles and 4-cycle data latency
    do_write(32'd1, 128'h1234, 2, 1'b0, 0);
    do_read(32'd1, 3, 4, 0);

    // Simultaneous requests: write wins, then a lone read goes through
    do_write(32'd7, rnd128(), 1, 1'b1, 2);
    do_read(32'd7, 0, 1, 0);

    // Requests held 10 cycles after completion
    do_write(32'd2, rnd128(), 0, 1'b0, 10);
    do_read(32'd2, 1, 2, 10);

    // Address wrap and ignored upper index bits
    do_write(32'hF0FF_FFFF, rnd128(), 0, 1'b0, 0);
    do_read(32'h0FFF_FFFF, 0, 3, 0);

    // Random mix
    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      a = {4'($urandom), 28'($urandom_range(0, 7))};
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, rnd128(), int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 2)));
      end else begin
        do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                int'($urandom_range(0, 2)));
      end
    end

    // Reset while waiting for read data, late valid afterwards
    do_read(32'd3, 0, 1, 0);
    sdram_address = 32'd4;
    rd_en = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("mid_rd_wait_no_read", avm_read, 1'b0);
    reset = 1'b0;
    rd_en = 1'b0;
    #1;
    check("mid_rst_read_data", read_data, '0);
    check("mid_rst_avm_read", avm_read, 1'b0);
    check("mid_rst_avm_address", avm_address, '0);
    check("mid_rst_read_complete", read_complete, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata = 128'hDEAD_BEEF;
    @(negedge clock);
    avm_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_valid_complete", read_complete, 1'b0);
      check("late_valid_data", read_data, '0);
      check("late_valid_no_bus", {avm_read, avm_write}, 2'b00);
      @(negedge clock);
    end
    do_write(32'd6, rnd128(), 1, 1'b0, 0);
    do_read(32'd6, 0, 2, 0);

`ifdef DDR3_BRIDGE_TIMEOUT_EN
    begin
      int nread;
      bit seen;
      nread = 0;
      seen  = 1'b0;
      avm_waitrequest = 1'b1;
      sdram_address   = 32'd9;
      rd_en           = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clock);
        if (avm_read) nread++;
        if (read_complete) seen = 1'b1;
      end
      check("tmo_complete_seen", seen, 1'b1);
      check("tmo_read_cycles", 32'(nread), 32'd16);
      check("tmo_read_data", read_data, '0);
      check("tmo_bridge_error", bridge_error, 1'b1);
      avm_waitrequest = 1'b0;
      rd_en = 1'b0;
      repeat (2) @(negedge clock);
      check("tmo_error_sticky", bridge_error, 1'b1);
    end
`else
    check("no_tmo_bridge_error", bridge_error, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
